i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- Downstream stage of the FIR filter. Takes the filter's 24-bit WaveOut word and serialises it to an external audio DAC in standard I2S format: BClk, LRClk, SData, MSB first, one-BCLK data delay.
- Generates all serial clocks from the system Clock.
- Emits a one-cycle FrameStrobe per audio frame, which upstream uses as its sample tick.
- Output is mono: the same latched sample is sent in the left and right slots.

Parameters:
- CLK_DIV, 8: system clocks per BCLK half-period; must be >= 1.
- SLOT_BITS, 32: BCLK periods per channel slot; must be >= SAMPLE_WIDTH.
- SAMPLE_WIDTH, 24: width of WaveIn.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  run/stop control for the serial interface.
- WaveIn  in  SAMPLE_WIDTH  two's-complement sample from the filter (WaveOut); free-running, no valid.
- BClk  out  1  I2S bit clock.
- LRClk  out  1  I2S word select; 0 = left, 1 = right.
- SData  out  1  I2S serial data.
- FrameStrobe  out  1  one-cycle pulse at frame start.

Behaviour:
- Reset (async, Reset=1): BClk=0, LRClk=0, SData=0, FrameStrobe=0, div_cnt=0, frame index f=2*SLOT_BITS-1, shadow=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while Enable=1.
  - On the wrap cycle, BClk toggles; otherwise div_cnt+1.
  - BCLK period is 2*CLK_DIV clocks.
  - First BClk rise occurs CLK_DIV clocks after Reset deasserts with Enable=1.
- Rising-edge wrap (BClk 0->1): only BClk changes. The DAC samples SData here.
- Falling-edge wrap (BClk 1->0), all registered in the same cycle:
  - f <= (f==2*SLOT_BITS-1) ? 0 : f+1.
  - LRClk <= new f >= SLOT_BITS.
  - SData <= bit(new f), defined below.
  - If new f==0: shadow <= WaveIn and FrameStrobe <= 1.
- FrameStrobe is 0 in every other cycle.
- Data mapping:
  - p = (f + 2*SLOT_BITS - 1) mod SLOT_BITS.
  - bit(f) = shadow[SAMPLE_WIDTH-1-p] if p < SAMPLE_WIDTH, else 0.
  - Exception: at f==0, bit = 0. This is p=SLOT_BITS-1, the padding tail of the previous right slot.
  - Net effect: MSB appears one BCLK after each LRClk edge; padding bits are 0.
- Latency: WaveIn is captured on the falling-wrap cycle entering f=0. The left MSB is driven at the next falling wrap, i.e. 2*CLK_DIV clocks later.
- Sample stability: shadow changes only at f=0. WaveIn changes mid-frame have no effect until the next frame.
- Enable=0, synchronous:
  - Next cycle: BClk=0, LRClk=0, SData=0, FrameStrobe=0, div_cnt=0, f=2*SLOT_BITS-1. Shadow is held.
  - Stays idle while Enable=0.
  - Re-enable restarts exactly as after reset, so the first frame begins with a fresh capture.
- Reset mid-frame: immediate return to reset values. No partial-frame completion is required.
- Arithmetic widths:
  - div_cnt: clog2(CLK_DIV)+1 bits.
  - f: clog2(2*SLOT_BITS) bits.
  - No signed arithmetic; bits pass through unmodified.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W=24 and I2S_SLOT_BITS=32 constants;
  - a sample_t typedef (24-bit logic);
  - a clog2 helper, if the toolflow lacks $clog2.
- One natural sub-module, bclk_divider: owns div_cnt and the BClk toggle; outputs rise_tick and fall_tick pulses.
- The top level holds the frame counter, shadow register, LRClk/SData/FrameStrobe logic.

Test Plan:
- Reset then Enable=1, CLK_DIV=2: first BClk rise 2 clocks after reset release; BClk period 4 clocks; FrameStrobe period 256 clocks, each pulse exactly 1 cycle wide.
- WaveIn=24'hA50F3C held: left slot SData over BCLK rises 1..24 = 1010_0101_0000_1111_0011_1100; bits 25..31 = 0; right slot identical; LRClk low for 32 BCLKs then high for 32.
- WaveIn=24'h800001 at capture, changed to 24'h7FFFFF mid-frame: current frame still sends 1 then 22 zeros then 1 in both slots; next frame sends 0 then 23 ones.
- LRClk/SData alignment: LRClk edge coincides with a BClk fall; MSB is on the following BClk fall; SData never changes on a BClk rise.
- Enable dropped mid-left-slot: next clock all outputs 0, no strobe. Re-enable: first FrameStrobe after 2*CLK_DIV clocks, fresh WaveIn captured.
- Reset asserted mid-right-slot, asynchronously between clock edges: outputs go 0 immediately. After release, timing is identical to the first scenario.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path constants and sample type for the FIR-to-DAC chain.
package audio_pkg;

  localparam int unsigned SAMPLE_W      = 24;
  localparam int unsigned I2S_SLOT_BITS = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/bclk_divider.sv
// Bit-clock generator: divides the system clock into BClk and flags each BClk edge.
module bclk_divider #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bclk,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned      DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap_c;

  // Wrap marks the cycle on which BClk toggles; the tick tells which way it goes.
  assign wrap_c      = enable && (div_cnt == DIV_LAST);
  assign rise_tick_c = wrap_c && !bclk;
  assign fall_tick_c = wrap_c && bclk;

  // Half-period counter and BClk toggle; disable parks both at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap_c) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// Mono I2S transmitter: latches one filter sample per frame and sends it MSB first
// in both slots, one BClk after each LRClk edge, with zero padding.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 8,
  parameter int unsigned SLOT_BITS    = I2S_SLOT_BITS,
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_W
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [SAMPLE_WIDTH-1:0] WaveIn,
  output logic                    BClk,
  output logic                    LRClk,
  output logic                    SData,
  output logic                    FrameStrobe
);

  localparam int unsigned    FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned    F_W        = $clog2(FRAME_BITS);
  localparam logic [F_W-1:0] F_LAST     = F_W'(FRAME_BITS - 1);
  localparam logic [F_W-1:0] F_SLOT     = F_W'(SLOT_BITS);
  localparam logic [F_W-1:0] P_TAIL     = F_W'(SLOT_BITS - 1);
  localparam logic [F_W-1:0] P_DATA     = F_W'(SAMPLE_WIDTH);

  logic                    rise_tick_c;
  logic                    fall_tick_c;

  logic [F_W-1:0]          f;
  logic [SAMPLE_WIDTH-1:0] shadow;

  logic [F_W-1:0]          f_step;
  logic [F_W-1:0]          pos_raw;
  logic [F_W-1:0]          slot_pos;
  logic [SAMPLE_WIDTH-1:0] shifted;
  logic                    bit_c;

  logic [F_W-1:0]          f_nxt;
  logic [SAMPLE_WIDTH-1:0] shadow_nxt;
  logic                    lrclk_nxt;
  logic                    sdata_nxt;
  logic                    strobe_nxt;

  bclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk        (Clock),
    .rst        (Reset),
    .enable     (Enable),
    .bclk       (BClk),
    .rise_tick_c(rise_tick_c),
    .fall_tick_c(fall_tick_c)
  );

  // Frame index, slot position and serial bit for the upcoming BClk period.
  always_comb begin
    f_step   = (f == F_LAST) ? '0 : f + F_W'(1);
    pos_raw  = f_step - F_W'(1);
    slot_pos = P_TAIL;
    if (f_step != '0) begin
      slot_pos = (pos_raw >= F_SLOT) ? pos_raw - F_SLOT : pos_raw;
    end
    shifted = shadow << slot_pos;
    bit_c   = (f_step != '0) && (slot_pos < P_DATA) && shifted[SAMPLE_WIDTH-1];
  end

  // Next-state for frame counter, shadow sample and registered serial outputs.
  always_comb begin
    f_nxt      = f;
    shadow_nxt = shadow;
    lrclk_nxt  = LRClk;
    sdata_nxt  = SData;
    strobe_nxt = 1'b0;
    if (!Enable) begin
      f_nxt     = F_LAST;
      lrclk_nxt = 1'b0;
      sdata_nxt = 1'b0;
    end else if (fall_tick_c) begin
      f_nxt     = f_step;
      lrclk_nxt = (f_step >= F_SLOT);
      sdata_nxt = bit_c;
      if (f_step == '0) begin
        shadow_nxt = WaveIn;
        strobe_nxt = 1'b1;
      end
    end
  end

  // State registers; async reset returns to the idle pre-frame position.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      f           <= F_LAST;
      shadow      <= '0;
      LRClk       <= 1'b0;
      SData       <= 1'b0;
      FrameStrobe <= 1'b0;
    end else begin
      f           <= f_nxt;
      shadow      <= shadow_nxt;
      LRClk       <= lrclk_nxt;
      SData       <= sdata_nxt;
      FrameStrobe <= strobe_nxt;
    end
  end

  // The divider never reports both BClk edges in one cycle.
  ticks_exclusive: assert property (@(posedge Clock) disable iff (Reset)
                                    !(rise_tick_c && fall_tick_c));

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: a negedge monitor checks every BClk rise against a queue of
// expected {LRClk, SData} pairs pushed at each frame capture.
module tb_i2s_dac_tx;
  import audio_pkg::*;

  localparam int unsigned DIV   = 2;
  localparam int unsigned SLOT  = 32;
  localparam int unsigned SW    = 24;
  localparam int          FRAME = 2 * SLOT;

  logic    Clock = 1'b0;
  logic    Reset;
  logic    Enable;
  sample_t WaveIn;
  logic    BClk;
  logic    LRClk;
  logic    SData;
  logic    FrameStrobe;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [1:0] sb[$];

  i2s_dac_tx #(
    .CLK_DIV     (DIV),
    .SLOT_BITS   (SLOT),
    .SAMPLE_WIDTH(SW)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .WaveIn     (WaveIn),
    .BClk       (BClk),
    .LRClk      (LRClk),
    .SData      (SData),
    .FrameStrobe(FrameStrobe)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference I2S bit for frame position k of sample s.
  function automatic logic exp_bit(input sample_t s, input int k);
    int p;
    if (k == 0) return 1'b0;
    p = (k - 1) % SLOT;
    if (p >= SW) return 1'b0;
    return s[SW-1-p];
  endfunction

  // Monitor: edge alignment, periods and scoreboard comparison.
  bit      idle = 1'b1;
  logic    prev_bclk = 1'b0, prev_lrclk = 1'b0, prev_sdata = 1'b0, prev_strobe = 1'b0;
  sample_t wave_prev = '0;
  int      last_rise = -1, last_strobe = -1;

  always @(negedge Clock) begin
    logic [1:0] e;
    if (Reset || !Enable) begin
      sb.delete();
      idle        = 1'b1;
      last_rise   = -1;
      last_strobe = -1;
    end else begin
      if (idle) begin
        sb.push_back(2'b00);
        idle = 1'b0;
      end
      if (BClk && !prev_bclk) begin
        check_eq("sdata_stable_on_rise", SData, prev_sdata);
        check_eq("lrclk_stable_on_rise", LRClk, prev_lrclk);
        if (last_rise >= 0) check_eq("bclk_period", cyc - last_rise, 2 * DIV);
        last_rise = cyc;
        check_eq("sb_avail", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("lrclk", LRClk, e[1]);
          check_eq("sdata", SData, e[0]);
        end
      end
      if (LRClk != prev_lrclk) check_eq("lrclk_edge_on_fall", prev_bclk && !BClk, 1);
      if (FrameStrobe) begin
        check_eq("strobe_width", prev_strobe, 0);
        if (last_strobe >= 0) check_eq("frame_period", cyc - last_strobe, FRAME * 2 * DIV);
        last_strobe = cyc;
        check_eq("sb_drained", sb.size(), 0);
        for (int k = 0; k < FRAME; k++) sb.push_back({1'(k >= SLOT), exp_bit(wave_prev, k)});
      end
    end
    prev_bclk   = BClk;
    prev_lrclk  = LRClk;
    prev_sdata  = SData;
    prev_strobe = FrameStrobe;
    wave_prev   = WaveIn;
  end

  task automatic check_idle(input string tag);
    check_eq({tag, "_bclk"}, BClk, 0);
    check_eq({tag, "_lrclk"}, LRClk, 0);
    check_eq({tag, "_sdata"}, SData, 0);
    check_eq({tag, "_strobe"}, FrameStrobe, 0);
  endtask

  // Called just after start is released: first BClk rise and first strobe latency.
  task automatic restart_timing(input string tag);
    int n = 0;
    int rise_at = 0;
    do begin
      @(posedge Clock);
      #1;
      n++;
      if (BClk && rise_at == 0) rise_at = n;
    end while (!FrameStrobe && n < 50);
    check_eq({tag, "_first_rise"}, rise_at, DIV);
    check_eq({tag, "_first_strobe"}, n, 2 * DIV);
  endtask

  task automatic wait_strobes(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int n = 0;
      do begin
        @(posedge Clock);
        #1;
        n++;
      end while (!FrameStrobe && n < 400);
      check_eq("strobe_arrives", FrameStrobe, 1);
    end
  endtask

  initial begin
    Reset  = 1'b1;
    Enable = 1'b1;
    WaveIn = 24'hA50F3C;
    repeat (3) @(posedge Clock);
    #1;
    check_idle("reset");
    Reset = 1'b0;
    restart_timing("rst1");
    wait_strobes(2);

    WaveIn = 24'h800001;
    wait_strobes(1);
    repeat (100) @(posedge Clock);
    #1;
    WaveIn = 24'h7FFFFF;
    wait_strobes(2);

    repeat (40) @(posedge Clock);
    #1;
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check_idle("disable");
    repeat (5) @(posedge Clock);
    #1;
    check_idle("disabled_hold");
    WaveIn = 24'h123456;
    Enable = 1'b1;
    restart_timing("reen");
    wait_strobes(2);

    repeat (150) @(posedge Clock);
    @(negedge Clock);
    #1;
    check_eq("pre_arst_right_slot", LRClk, 1);
    Reset = 1'b1;
    #1;
    check_idle("arst");
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    restart_timing("rst2");
    WaveIn = 24'h5A5A5A;
    wait_strobes(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
